aes_key_expand: RTL and testbench
=================================

Name: aes_key_expand

Overview:
AES-128 key-schedule stage that sits directly downstream of interfaceAES. It consumes the 128-bit key assembled by the bus interface plus its initiate strobe. It then produces the 11 round keys (round 0 to round 10) one at a time, using a valid/ready handshake, for the AES round datapath. The schedule is computed on the fly, one round per accepted handshake, with no storage of the full expanded key.

Parameters:
NR, 10, number of AES rounds; the last round-key index. Fixed at 10 for AES-128; any other value is unsupported.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
key  input  128 [0:127]  cipher key; bit 0 is the MSB of byte 0; sampled only when start is accepted
start  input  1  request to begin expansion (driven from interfaceAES initiate)
rk_ready  input  1  consumer accepts the current round key
round_key  output  128 [0:127]  current round key, words w0..w3 with w0 = bits 0..31
rk_index  output  4  index of the round key on round_key (0..10)
rk_valid  output  1  round_key/rk_index are valid
busy  output  1  expansion in progress; start is ignored while high
done  output  1  one-cycle pulse after round key 10 is accepted

Behaviour:
- Reset (reset=0, async): state=IDLE, round_key=0, rk_index=0, rk_valid=0, busy=0, done=0, Rcon register=8'h01.
- FSM has two states, IDLE and ACTIVE.
- IDLE transition: start=1 at a rising edge -> next cycle: round_key=key, rk_index=0, rk_valid=1, busy=1, Rcon=8'h01, state=ACTIVE.
- IDLE latency: start to first valid is 1 cycle.
- ACTIVE, rk_valid=1 and rk_ready=0: hold round_key, rk_index and rk_valid stable (no bubble, no change).
- ACTIVE handshake (rk_valid=1 and rk_ready=1) with rk_index<NR: next cycle holds round key rk_index+1, computed as follows.
  - t = SubWord(RotWord(w3)) XOR {Rcon,24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Rcon advances as xtime: {Rcon[6:0],1'b0} XOR (Rcon[7] ? 8'h1b : 0).
  - Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
  - Throughput is one round key per cycle when rk_ready is held high.
- ACTIVE handshake with rk_index==NR: next cycle rk_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE. round_key and rk_index keep their last values.
- RotWord: cyclic left byte rotate, {b1,b2,b3,b0}.
- SubWord: the FIPS-197 S-box applied to each of the 4 bytes. It is implemented combinationally inside this block as a 256-entry lookup function.
- start while busy=1: ignored, and key is not sampled.
- start in the same cycle as the final handshake: ignored. A new start is accepted only in IDLE, at the earliest on the done cycle.
- rk_ready while rk_valid=0: no effect.
- Reset mid-expansion: immediate return to reset values. No done pulse, and no partial round keys after reset deasserts.
- key changing while busy: no effect.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle, rk_ready=1 held:
  - round 0 = key, 1 cycle after start.
  - round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at rk_index=10, 11 cycles after start.
  - done pulses on the next cycle; busy then drops.
- All-zero key, rk_ready=1:
  - round 1 = 62636363626363636263636362636363.
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: FIPS key with rk_ready toggled 1,0,0,1,...
  - round_key and rk_index are stable every cycle rk_ready=0.
  - the same 11 keys appear in order, with none skipped or repeated.
- start pulsed again at rk_index=4 with key all-ones -> ignored; the sequence finishes with the FIPS round 10 value.
- Reset asserted (0) asynchronously mid-clock at rk_index=6:
  - outputs go to 0 immediately, with no done pulse.
  - after release, a fresh start gives round 0 = the newly presented key.
- Back-to-back: start asserted on the done cycle with the zero key -> accepted; rk_valid=1 with rk_index=0 on the next cycle.

Source files
------------

// File: rtl/aes_key_expand.sv
// AES-128 key-schedule stage: emits round keys 0..NR one per accepted
// valid/ready handshake, deriving each key from the previous one on the fly.
module aes_key_expand #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] key,
    input  logic         start,
    input  logic         rk_ready,
    output logic [0:127] round_key,
    output logic [3:0]   rk_index,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Byte b lives at bit offset 8*(255-b), which is simply {~b, 3'b000}.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
                sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
    endfunction

    // GF(2^8) doubling used to step the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] next_round_key(input logic [0:127] rk,
                                                    input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = rk[0:31];
        w1 = rk[32:63];
        w2 = rk[64:95];
        w3 = rk[96:127];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       state_q, state_d;
    logic [0:127] round_key_q, round_key_d;
    logic [3:0]   rk_index_q, rk_index_d;
    logic         rk_valid_q, rk_valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [7:0]   rcon_q, rcon_d;

    // Next-state logic: load key on start, advance one round per handshake.
    always_comb begin
        state_d     = state_q;
        round_key_d = round_key_q;
        rk_index_d  = rk_index_q;
        rk_valid_d  = rk_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rcon_d      = rcon_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ACTIVE;
                    round_key_d = key;
                    rk_index_d  = 4'd0;
                    rk_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    rcon_d      = 8'h01;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_index_q < NR_IDX) begin
                        round_key_d = next_round_key(round_key_q, rcon_q);
                        rk_index_d  = rk_index_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end else begin
                        // Final key consumed: keep last key/index visible.
                        state_d    = ST_IDLE;
                        rk_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                round_key_d = 128'h0;
                rk_index_d  = 4'd0;
                rk_valid_d  = 1'b0;
                busy_d      = 1'b0;
                rcon_d      = 8'h01;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            round_key_q <= 128'h0;
            rk_index_q  <= 4'd0;
            rk_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rcon_q      <= 8'h01;
        end else begin
            state_q     <= state_d;
            round_key_q <= round_key_d;
            rk_index_q  <= rk_index_d;
            rk_valid_q  <= rk_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rcon_q      <= rcon_d;
        end
    end

    assign round_key = round_key_q;
    assign rk_index  = rk_index_q;
    assign rk_valid  = rk_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;

    logic         clk;
    logic         reset;
    logic [0:127] key;
    logic         start;
    logic         rk_ready;
    logic [0:127] round_key;
    logic [3:0]   rk_index;
    logic         rk_valid;
    logic         busy;
    logic         done;

    int tests_run;
    int tests_failed;

    logic [127:0] fips_rk [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;
    localparam logic [127:0] ONES_KEY = {128{1'b1}};
    localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    aes_key_expand #(.NR(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .start     (start),
        .rk_ready  (rk_ready),
        .round_key (round_key),
        .rk_index  (rk_index),
        .rk_valid  (rk_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an expansion with rk_ready held high and walk all 11 keys.
    task automatic run_full(input string tag, input logic [127:0] k,
                            input logic [127:0] r1, input logic [127:0] r10);
        key = k; start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            check_eq({tag, "_valid"}, rk_valid, 1);
            check_eq({tag, "_idx"}, rk_index, i);
            if (i == 0)  check_eq({tag, "_r0"}, round_key, k);
            if (i == 1)  check_eq({tag, "_r1"}, round_key, r1);
            if (i == 10) check_eq({tag, "_r10"}, round_key, r10);
            @(negedge clk);
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_end_valid"}, rk_valid, 0);
        check_eq({tag, "_end_busy"}, busy, 0);
        check_eq({tag, "_hold_key"}, round_key, r10);
        check_eq({tag, "_hold_idx"}, rk_index, 10);
    endtask

    initial begin
        int exp_idx;
        int pat;
        int cyc;

        tests_run = 0; tests_failed = 0;
        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        reset = 1'b0; key = FIPS_KEY; start = 1'b0; rk_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_key", round_key, 0);
        check_eq("rst_idx", rk_index, 0);
        check_eq("rst_valid", rk_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // FIPS-197 vector, full throughput.
        run_full("fips", FIPS_KEY, fips_rk[1], fips_rk[10]);
        @(negedge clk);
        check_eq("fips_done_pulse", done, 0);

        // Backpressure 1,0,0,1 with an ignored restart at index 4 and a
        // start coinciding with the final handshake.
        key = FIPS_KEY; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        exp_idx = 0; pat = 0; cyc = 0;
        while (exp_idx <= 10 && cyc < 100) begin
            check_eq("bp_valid", rk_valid, 1);
            check_eq("bp_idx", rk_index, exp_idx);
            check_eq("bp_key", round_key, fips_rk[exp_idx]);
            rk_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            pat++;
            start = (exp_idx == 4) || (exp_idx == 10 && rk_ready);
            key   = start ? ONES_KEY : FIPS_KEY;
            if (rk_ready) exp_idx++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; rk_ready = 1'b0;
        check_eq("bp_count", exp_idx, 11);
        check_eq("bp_done", done, 1);
        check_eq("bp_end_valid", rk_valid, 0);
        check_eq("bp_final_key", round_key, fips_rk[10]);
        @(negedge clk);
        check_eq("bp_no_restart", rk_valid, 0);
        check_eq("bp_done_pulse", done, 0);

        // All-zero key, then back-to-back start on the done cycle.
        run_full("zero", ZERO_KEY, ZERO_R1, ZERO_R10);
        key = ZERO_KEY; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_valid", rk_valid, 1);
        check_eq("b2b_idx", rk_index, 0);
        check_eq("b2b_key", round_key, ZERO_KEY);

        // Asynchronous reset in the middle of the clock low phase at index 6.
        rk_ready = 1'b1;
        cyc = 0;
        while (rk_index != 4'd6 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("mid_idx", rk_index, 6);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_key", round_key, 0);
        check_eq("arst_idx", rk_index, 0);
        check_eq("arst_valid", rk_valid, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", rk_valid, 0);
            check_eq("post_rst_done", done, 0);
            check_eq("post_rst_busy", busy, 0);
        end
        key = ONES_KEY; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("restart_valid", rk_valid, 1);
        check_eq("restart_idx", rk_index, 0);
        check_eq("restart_key", round_key, ONES_KEY);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
